// File: rtl/id_ex_stage_register_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: default data width,
// register-index width and the packed decoder control bundle.
package id_ex_stage_register_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int REG_ADDR_W         = 5;

  typedef struct packed {
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] alu_operand_a_selector;
    logic       alu_operand_b_selector;
    logic [1:0] next_pc_selector;
    logic [2:0] alu_operations_selector;
  } ctrl_t;

  // Strips every bit that could change architectural state or redirect fetch.
  function automatic ctrl_t ctrl_kill(input ctrl_t c);
    ctrl_t r;
    r                  = c;
    r.write            = 1'b0;
    r.store            = 1'b0;
    r.load             = 1'b0;
    r.branch           = 1'b0;
    r.next_pc_selector = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection: a load in EX whose destination feeds either
// source of the instruction in ID stalls decode for one cycle.
module load_use_hazard_unit
  import id_ex_stage_register_pkg::*;
(
  input  logic                  ex_valid_i,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_address_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_address_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_address_i,
  input  logic                  flush_i,
  output logic                  stall_o
);

  logic rd_live;
  logic src_match;

  // Both sources are compared for every format; a spurious stall is harmless.
  assign rd_live   = ex_valid_i & ex_load_i & (ex_rd_address_i != '0);
  assign src_match = (ex_rd_address_i == id_rs1_address_i) |
                     (ex_rd_address_i == id_rs2_address_i);
  assign stall_o   = rd_live & id_valid_i & src_match & ~flush_i;

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Define STALL_COUNTER_EN to build the saturating load-use stall-cycle counter.
module id_ex_stage_register
  import id_ex_stage_register_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_write,
  input  logic                  id_store,
  input  logic                  id_load,
  input  logic                  id_branch,
  input  logic [1:0]            id_alu_operand_a_selector,
  input  logic                  id_alu_operand_b_selector,
  input  logic [1:0]            id_next_pc_selector,
  input  logic [2:0]            id_alu_operations_selector,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7_bit5,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_immediate,
  input  logic [REG_ADDR_W-1:0] id_rs1_address,
  input  logic [REG_ADDR_W-1:0] id_rs2_address,
  input  logic [REG_ADDR_W-1:0] id_rd_address,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  ex_write,
  output logic                  ex_store,
  output logic                  ex_load,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_operand_a_selector,
  output logic                  ex_alu_operand_b_selector,
  output logic [1:0]            ex_next_pc_selector,
  output logic [2:0]            ex_alu_operations_selector,
  output logic [2:0]            ex_funct3,
  output logic                  ex_funct7_bit5,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [DATA_WIDTH-1:0] ex_immediate,
  output logic [REG_ADDR_W-1:0] ex_rs1_address,
  output logic [REG_ADDR_W-1:0] ex_rs2_address,
  output logic [REG_ADDR_W-1:0] ex_rd_address,
  output logic                  stall,
  output logic [31:0]           stall_cycle_count
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl_q, ex_ctrl_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [2:0]            ex_funct3_q, ex_funct3_d;
  logic                  ex_funct7_bit5_q, ex_funct7_bit5_d;
  logic [DATA_WIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [DATA_WIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [DATA_WIDTH-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [DATA_WIDTH-1:0] ex_immediate_q, ex_immediate_d;
  logic [REG_ADDR_W-1:0] ex_rs1_address_q, ex_rs1_address_d;
  logic [REG_ADDR_W-1:0] ex_rs2_address_q, ex_rs2_address_d;
  logic [REG_ADDR_W-1:0] ex_rd_address_q, ex_rd_address_d;

  assign id_ctrl = '{
    write:                   id_write,
    store:                   id_store,
    load:                    id_load,
    branch:                  id_branch,
    alu_operand_a_selector:  id_alu_operand_a_selector,
    alu_operand_b_selector:  id_alu_operand_b_selector,
    next_pc_selector:        id_next_pc_selector,
    alu_operations_selector: id_alu_operations_selector
  };

  load_use_hazard_unit u_hazard (
    .ex_valid_i       (ex_valid_q),
    .ex_load_i        (ex_ctrl_q.load),
    .ex_rd_address_i  (ex_rd_address_q),
    .id_valid_i       (id_valid),
    .id_rs1_address_i (id_rs1_address),
    .id_rs2_address_i (id_rs2_address),
    .flush_i          (flush),
    .stall_o          (stall)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    ex_valid_d       = id_valid;
    ex_ctrl_d        = id_valid ? id_ctrl : ctrl_kill(id_ctrl);
    ex_funct3_d      = id_funct3;
    ex_funct7_bit5_d = id_funct7_bit5;
    ex_pc_d          = id_pc;
    ex_rs1_data_d    = id_rs1_data;
    ex_rs2_data_d    = id_rs2_data;
    ex_immediate_d   = id_immediate;
    ex_rs1_address_d = id_rs1_address;
    ex_rs2_address_d = id_rs2_address;
    ex_rd_address_d  = id_rd_address;
    // Flush and stall both inject an all-zero bubble; stall is already masked by flush.
    if (flush || stall) begin
      ex_valid_d       = 1'b0;
      ex_ctrl_d        = '0;
      ex_funct3_d      = '0;
      ex_funct7_bit5_d = 1'b0;
      ex_pc_d          = '0;
      ex_rs1_data_d    = '0;
      ex_rs2_data_d    = '0;
      ex_immediate_d   = '0;
      ex_rs1_address_d = '0;
      ex_rs2_address_d = '0;
      ex_rd_address_d  = '0;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and beats flush/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q       <= 1'b0;
      ex_ctrl_q        <= '0;
      ex_funct3_q      <= '0;
      ex_funct7_bit5_q <= 1'b0;
      ex_pc_q          <= '0;
      ex_rs1_data_q    <= '0;
      ex_rs2_data_q    <= '0;
      ex_immediate_q   <= '0;
      ex_rs1_address_q <= '0;
      ex_rs2_address_q <= '0;
      ex_rd_address_q  <= '0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_ctrl_q        <= ex_ctrl_d;
      ex_funct3_q      <= ex_funct3_d;
      ex_funct7_bit5_q <= ex_funct7_bit5_d;
      ex_pc_q          <= ex_pc_d;
      ex_rs1_data_q    <= ex_rs1_data_d;
      ex_rs2_data_q    <= ex_rs2_data_d;
      ex_immediate_q   <= ex_immediate_d;
      ex_rs1_address_q <= ex_rs1_address_d;
      ex_rs2_address_q <= ex_rs2_address_d;
      ex_rd_address_q  <= ex_rd_address_d;
    end
  end

  assign ex_valid                   = ex_valid_q;
  assign ex_write                   = ex_ctrl_q.write;
  assign ex_store                   = ex_ctrl_q.store;
  assign ex_load                    = ex_ctrl_q.load;
  assign ex_branch                  = ex_ctrl_q.branch;
  assign ex_alu_operand_a_selector  = ex_ctrl_q.alu_operand_a_selector;
  assign ex_alu_operand_b_selector  = ex_ctrl_q.alu_operand_b_selector;
  assign ex_next_pc_selector        = ex_ctrl_q.next_pc_selector;
  assign ex_alu_operations_selector = ex_ctrl_q.alu_operations_selector;
  assign ex_funct3                  = ex_funct3_q;
  assign ex_funct7_bit5             = ex_funct7_bit5_q;
  assign ex_pc                      = ex_pc_q;
  assign ex_rs1_data                = ex_rs1_data_q;
  assign ex_rs2_data                = ex_rs2_data_q;
  assign ex_immediate               = ex_immediate_q;
  assign ex_rs1_address             = ex_rs1_address_q;
  assign ex_rs2_address             = ex_rs2_address_q;
  assign ex_rd_address              = ex_rd_address_q;

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycle_count = stall_cnt_q;
`else
  assign stall_cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Scoreboard bench for id_ex_stage_register: a driver applies directed then
// random instructions and queues the expected outputs; a monitor compares them.
module tb_id_ex_stage_register;

  localparam int DW = 32;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [1:0] npc_sel;
    logic [2:0] alu_sel;
    logic [2:0] funct3;
    logic       f7b5;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] imm;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
  } stage_t;

  typedef struct {
    stage_t      ex;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush;
  stage_t id_in;
  stage_t ex_out;
  logic ex_valid, ex_write, ex_store, ex_load, ex_branch, ex_b_sel, ex_f7b5, stall;
  logic [1:0] ex_a_sel, ex_npc_sel;
  logic [2:0] ex_alu_sel, ex_funct3;
  logic [DW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [31:0] stall_cycle_count;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  stage_t model_ex, model_next;
  logic [31:0] model_cnt, model_cnt_next;

  always #5 clk = ~clk;

  id_ex_stage_register #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_in.valid), .id_write(id_in.write), .id_store(id_in.store),
    .id_load(id_in.load), .id_branch(id_in.branch),
    .id_alu_operand_a_selector(id_in.a_sel), .id_alu_operand_b_selector(id_in.b_sel),
    .id_next_pc_selector(id_in.npc_sel), .id_alu_operations_selector(id_in.alu_sel),
    .id_funct3(id_in.funct3), .id_funct7_bit5(id_in.f7b5),
    .id_pc(id_in.pc), .id_rs1_data(id_in.rs1_data), .id_rs2_data(id_in.rs2_data),
    .id_immediate(id_in.imm), .id_rs1_address(id_in.rs1_addr),
    .id_rs2_address(id_in.rs2_addr), .id_rd_address(id_in.rd_addr),
    .flush(flush),
    .ex_valid(ex_valid), .ex_write(ex_write), .ex_store(ex_store), .ex_load(ex_load),
    .ex_branch(ex_branch), .ex_alu_operand_a_selector(ex_a_sel),
    .ex_alu_operand_b_selector(ex_b_sel), .ex_next_pc_selector(ex_npc_sel),
    .ex_alu_operations_selector(ex_alu_sel), .ex_funct3(ex_funct3),
    .ex_funct7_bit5(ex_f7b5), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_immediate(ex_imm), .ex_rs1_address(ex_rs1_addr),
    .ex_rs2_address(ex_rs2_addr), .ex_rd_address(ex_rd_addr),
    .stall(stall), .stall_cycle_count(stall_cycle_count)
  );

  assign ex_out = '{valid: ex_valid, write: ex_write, store: ex_store, load: ex_load,
                    branch: ex_branch, a_sel: ex_a_sel, b_sel: ex_b_sel,
                    npc_sel: ex_npc_sel, alu_sel: ex_alu_sel, funct3: ex_funct3,
                    f7b5: ex_f7b5, pc: ex_pc, rs1_data: ex_rs1_data,
                    rs2_data: ex_rs2_data, imm: ex_imm, rs1_addr: ex_rs1_addr,
                    rs2_addr: ex_rs2_addr, rd_addr: ex_rd_addr};

  task automatic check(input string name, input logic [$bits(stage_t)-1:0] act,
                       input logic [$bits(stage_t)-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: a load in EX with a nonzero destination that either
  // source of a live ID instruction names stalls, unless a flush is present.
  function automatic logic ref_stall(input stage_t ex, input stage_t id, input logic fl);
    return ex.valid && ex.load && ex.rd_addr != 5'd0 && id.valid &&
           (ex.rd_addr == id.rs1_addr || ex.rd_addr == id.rs2_addr) && !fl;
  endfunction

  // Drive one cycle of inputs, queue what should be seen before the coming edge,
  // and work out what the register should hold after it.
  task automatic apply(input stage_t id, input logic r, input logic fl);
    exp_t e;
    logic s;
    id_in = id;
    rst   = r;
    flush = fl;
    s = ref_stall(model_ex, id, fl);
    e.ex = model_ex; e.stall = s; e.cnt = model_cnt;
    sb.push_back(e);
    if (r || fl || s) model_next = '0;
    else begin
      model_next = id;
      if (!id.valid) begin
        model_next.write = 0; model_next.store = 0; model_next.load = 0;
        model_next.branch = 0; model_next.npc_sel = 0;
      end
    end
`ifdef STALL_COUNTER_EN
    if (r) model_cnt_next = 0;
    else if (s && model_cnt != 32'hFFFF_FFFF) model_cnt_next = model_cnt + 1;
    else model_cnt_next = model_cnt;
`else
    model_cnt_next = 0;
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_ex  = model_next;
    model_cnt = model_cnt_next;
  endtask

  function automatic stage_t rand_stage();
    stage_t s;
    s = '0;
    s.valid   = ($urandom_range(0, 3) != 0);
    s.write   = $urandom_range(0, 1) != 0;
    s.store   = $urandom_range(0, 1) != 0;
    s.load    = $urandom_range(0, 1) != 0;
    s.branch  = $urandom_range(0, 1) != 0;
    s.a_sel   = 2'($urandom_range(0, 3));
    s.b_sel   = $urandom_range(0, 1) != 0;
    s.npc_sel = 2'($urandom_range(0, 3));
    s.alu_sel = 3'($urandom_range(0, 7));
    s.funct3  = 3'($urandom_range(0, 7));
    s.f7b5    = $urandom_range(0, 1) != 0;
    s.pc = $urandom; s.rs1_data = $urandom; s.rs2_data = $urandom; s.imm = $urandom;
    // Small register range keeps hazards frequent.
    s.rs1_addr = 5'($urandom_range(0, 3));
    s.rs2_addr = 5'($urandom_range(0, 3));
    s.rd_addr  = 5'($urandom_range(0, 3));
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ex_bundle", ex_out, e.ex);
        check("stall", {159'd0, stall}, {159'd0, e.stall});
        check("stall_count", {128'd0, stall_cycle_count}, {128'd0, e.cnt});
      end
    end
  end

  initial begin : driver
    stage_t lw, add, pl;
    logic [31:0] cnt_before;
    id_in = '0; rst = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    model_ex = '0; model_cnt = 0;

    // Reset state
    check("reset_ex", ex_out, '0);
    check("reset_count", {128'd0, stall_cycle_count}, '0);

    // Plain transfer
    pl = '0; pl.valid = 1; pl.pc = 32'h40; pl.imm = 32'h10; pl.write = 1;
    apply(pl, 0, 0); advance();
    check("plain_pc", {128'd0, ex_pc}, {128'd0, 32'h40});
    check("plain_imm", {128'd0, ex_imm}, {128'd0, 32'h10});
    check("plain_write_valid", {158'd0, ex_write, ex_valid}, {158'd0, 2'b11});

    // Load-use on rd=5
    lw = '0; lw.valid = 1; lw.load = 1; lw.write = 1; lw.rd_addr = 5'd5; lw.rs1_addr = 5'd2;
    add = '0; add.valid = 1; add.write = 1; add.rs1_addr = 5'd5; add.rs2_addr = 5'd7;
    add.rd_addr = 5'd6; add.pc = 32'h44;
    apply(lw, 0, 0); advance();
    apply(add, 0, 0); #1;
    check("loaduse_stall", {159'd0, stall}, {159'd0, 1'b1});
    advance();
    check("loaduse_bubble", ex_out, '0);
`ifdef STALL_COUNTER_EN
    check("loaduse_count", {128'd0, stall_cycle_count}, {128'd0, 32'd1});
`else
    check("loaduse_count", {128'd0, stall_cycle_count}, {128'd0, 32'd0});
`endif
    apply(add, 0, 0); #1;
    check("loaduse_one_cycle", {159'd0, stall}, '0);
    advance();
    check("loaduse_capture", {128'd0, ex_pc}, {128'd0, 32'h44});

    // rd = x0 is never a hazard
    lw.rd_addr = 5'd0; add.rs1_addr = 5'd0;
    apply(lw, 0, 0); advance();
    apply(add, 0, 0); #1;
    check("x0_no_stall", {159'd0, stall}, '0);
    advance();
    check("x0_no_bubble", {159'd0, ex_valid}, {159'd0, 1'b1});

    // Flush beats stall
    lw.rd_addr = 5'd5; add.rs1_addr = 5'd5;
    apply(lw, 0, 0); advance();
    cnt_before = stall_cycle_count;
    apply(add, 0, 1); #1;
    check("flush_masks_stall", {159'd0, stall}, '0);
    advance();
    check("flush_bubble", ex_out, '0);
    check("flush_count", {128'd0, stall_cycle_count}, {128'd0, cnt_before});

    // Reset mid-stream with a pending hazard
    apply(lw, 0, 0); advance();
    apply(add, 1, 0); advance();
    check("rst_ex", ex_out, '0);
    check("rst_count", {128'd0, stall_cycle_count}, '0);
    apply(add, 0, 0); #1;
    check("rst_no_stall", {159'd0, stall}, '0);
    advance();

`ifdef STALL_COUNTER_EN
    // Saturation
    apply(lw, 0, 0); advance();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    apply(add, 0, 0); advance();
    check("sat_count", {128'd0, stall_cycle_count}, {128'd0, 32'hFFFF_FFFF});
    apply(lw, 1, 0); advance();
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      apply(rand_stage(), ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0));
      advance();
    end

    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_register.md
ID_EX_STAGE_REGISTER -- requirements
Module: id_ex_stage_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC, register-operand and immediate paths.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_write, id_store, id_load, id_branch  in  1 each  decoder control bits.
- id_alu_operand_a_selector  in  2  decoder control field.
- id_alu_operand_b_selector  in  1  decoder control field.
- id_next_pc_selector  in  2  decoder control field.
- id_alu_operations_selector  in  3  decoder control field.
- id_funct3  in  3  instruction funct3.
- id_funct7_bit5  in  1  instruction bit 30.
- id_pc, id_rs1_data, id_rs2_data, id_immediate  in  DATA_WIDTH each  decode-stage data.
- id_rs1_address, id_rs2_address, id_rd_address  in  5 each  register indices.
- flush  in  1  taken branch/jump redirect from execute.
- ex_* outputs  out  same widths  registered copies of every id_* input above, including ex_valid.
- stall  out  1  combinational; holds PC and IF/ID register.
- stall_cycle_count  out  32  load-use stall cycles counted.

Function
REQ-003 SHALL assert stall combinationally when ex_valid & ex_load & ex_rd_address!=0 & id_valid & (ex_rd_address==id_rs1_address | ex_rd_address==id_rs2_address) & ~flush.
REQ-004 SHALL compare both source indices regardless of instruction format; conservative stalls are accepted.
REQ-005 SHALL, on each rising edge with no flush and no stall, load every ex_* output from its id_* input; latency one cycle.
REQ-006 SHALL, on an edge with stall asserted, insert a bubble: ex_valid, ex_write, ex_store, ex_load, ex_branch and ex_next_pc_selector cleared to 0; all other ex_* fields SHALL also be cleared to 0.
REQ-007 SHALL, on an edge with flush asserted, insert the same bubble; flush SHALL take priority over stall.
REQ-008 SHALL force ex_write, ex_store, ex_load, ex_branch and ex_next_pc_selector to 0 whenever id_valid is 0 at capture.
REQ-009 SHALL limit each load-use hazard to exactly one stall cycle, since the bubble clears ex_load.
REQ-010 SHALL treat ex_rd_address==0 as never hazardous.
REQ-011 SHALL contain no other state besides the pipeline register and the optional counter.

Reset
REQ-012 SHALL, while rst is high at an edge, clear every ex_* output to 0; rst SHALL override flush and stall.
REQ-013 SHALL clear stall_cycle_count to 0 on rst.
REQ-014 SHALL drive stall at 0 in the cycle after reset, because ex_valid is then 0.

Configuration
REQ-015 SHALL, with STALL_COUNTER_EN defined, increment stall_cycle_count by 1 on every edge where stall is 1 and rst is 0, saturating at 32'hFFFF_FFFF.
REQ-016 SHALL, without STALL_COUNTER_EN, keep the stall_cycle_count port and tie it to constant 0 with no counter flops.

Structure
REQ-017 SHALL take DATA_WIDTH default, register-index width (5) and a packed control-bundle typedef (write, store, load, branch, selectors) from the shared pipeline package.
REQ-018 SHALL place the REQ-003 comparison logic in one sub-module, load_use_hazard_unit; the register and counter stay in the top.

Verification
REQ-019 SHALL cover these directed scenarios:
- Plain transfer: id_valid=1, id_pc=0x0000_0040, id_immediate=0x0000_0010, id_write=1 -> next cycle ex_pc=0x40, ex_immediate=0x10, ex_write=1, ex_valid=1.
- Load-use: ex lw with rd=5; id add with rs1=5 -> stall=1 for one cycle, bubble ex_valid=0, next cycle add captured; with STALL_COUNTER_EN, count goes 0->1.
- rd=x0: ex lw with rd=0, id rs1=0 -> stall=0, no bubble.
- Flush vs stall: same hazard as scenario 2 plus flush=1 -> stall=0, bubble captured, count unchanged.
- Reset mid-stream: rst=1 while ex_load=1 and a hazard is pending -> all ex_* outputs 0 and stall_cycle_count 0 after the edge; stall=0 in the following cycle.
- Saturation (STALL_COUNTER_EN): counter forced to 0xFFFF_FFFF, hazard applied -> count stays 0xFFFF_FFFF.
